// File: rtl/serial_transmitter.sv
// serial_transmitter: start/data/stop serial line transmitter with a
// valid/ready byte input. The line idles high. Each frame is a start bit (0),
// DATA_W data bits LSB first, and a stop bit (1). Every bit is held for
// CLKS_PER_BIT clocks.
// Optional build macro SERIAL_TX_PARITY_EN inserts an even-parity bit
// between the last data bit and the stop bit.
// All outputs are registered. They are derived from the next-state values,
// so each output changes on the same edge as the state it describes.
module serial_transmitter #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              tx_valid,
   input  logic [DATA_W-1:0] tx_data,
   output logic              tx_ready,
   output logic              tx,
   output logic              busy,
   output logic              done
);

   localparam int              BCW      = $clog2(DATA_W + 1);
   localparam logic [15:0]     DIV_LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic [BCW-1:0]  BIT_LAST = BCW'(DATA_W - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY = 3'd4,
`endif
      S_STOP   = 3'd3
   } state_t;

`ifdef SERIAL_TX_PARITY_EN
   // Even parity: XOR of every data bit.
   function automatic logic even_parity(input logic [DATA_W-1:0] d);
      return ^d;
   endfunction
`endif

   state_t             r_state, w_state_n;
   logic [15:0]        r_div, w_div_n;
   logic [BCW-1:0]     r_bit_cnt, w_bit_n;
   logic [DATA_W-1:0]  r_shift, w_shift_n;
   logic               r_tx, w_tx_n;
   logic               r_ready, w_ready_n;
   logic               r_busy, w_busy_n;
   logic               r_done, w_done_n;
   logic               w_div_end;
`ifdef SERIAL_TX_PARITY_EN
   logic               r_parity, w_parity_n;
`endif

   // Next-state, counter, shift register and registered-output decode.
   always_comb begin
      w_state_n = r_state;
      w_div_n   = r_div;
      w_bit_n   = r_bit_cnt;
      w_shift_n = r_shift;
      w_div_end = (r_div == DIV_LAST);
`ifdef SERIAL_TX_PARITY_EN
      w_parity_n = r_parity;
`endif
      case (r_state)
         S_IDLE: begin
            w_div_n = 16'd0;
            w_bit_n = '0;
            if (tx_valid && r_ready) begin
               w_state_n = S_START;
               w_shift_n = tx_data;
`ifdef SERIAL_TX_PARITY_EN
               w_parity_n = even_parity(tx_data);
`endif
            end else begin
               w_state_n = S_IDLE;
            end
         end
         S_START: begin
            if (w_div_end) begin
               w_div_n   = 16'd0;
               w_bit_n   = '0;
               w_state_n = S_DATA;
            end else begin
               w_div_n = r_div + 16'd1;
            end
         end
         S_DATA: begin
            if (w_div_end) begin
               w_div_n = 16'd0;
               if (r_bit_cnt == BIT_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
                  w_state_n = S_PARITY;
`else
                  w_state_n = S_STOP;
`endif
               end else begin
                  w_shift_n = r_shift >> 1;
                  w_bit_n   = r_bit_cnt + {{(BCW-1){1'b0}}, 1'b1};
               end
            end else begin
               w_div_n = r_div + 16'd1;
            end
         end
`ifdef SERIAL_TX_PARITY_EN
         S_PARITY: begin
            if (w_div_end) begin
               w_div_n   = 16'd0;
               w_state_n = S_STOP;
            end else begin
               w_div_n = r_div + 16'd1;
            end
         end
`endif
         S_STOP: begin
            if (w_div_end) begin
               w_div_n   = 16'd0;
               w_state_n = S_IDLE;
            end else begin
               w_div_n = r_div + 16'd1;
            end
         end
         default: begin
            w_state_n = S_IDLE;
            w_div_n   = 16'd0;
            w_bit_n   = '0;
         end
      endcase

      case (w_state_n)
         S_IDLE:   w_tx_n = 1'b1;
         S_START:  w_tx_n = 1'b0;
         S_DATA:   w_tx_n = w_shift_n[0];
`ifdef SERIAL_TX_PARITY_EN
         S_PARITY: w_tx_n = w_parity_n;
`endif
         S_STOP:   w_tx_n = 1'b1;
         default:  w_tx_n = 1'b1;
      endcase

      w_ready_n = (w_state_n == S_IDLE);
      w_busy_n  = ~w_ready_n;
      w_done_n  = (w_state_n == S_STOP) && (w_div_n == DIV_LAST);
   end

   // State and output registers; synchronous reset aborts any frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_div     <= 16'd0;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_tx      <= 1'b1;
         r_ready   <= 1'b1;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
         r_parity  <= 1'b0;
`endif
      end else begin
         r_state   <= w_state_n;
         r_div     <= w_div_n;
         r_bit_cnt <= w_bit_n;
         r_shift   <= w_shift_n;
         r_tx      <= w_tx_n;
         r_ready   <= w_ready_n;
         r_busy    <= w_busy_n;
         r_done    <= w_done_n;
`ifdef SERIAL_TX_PARITY_EN
         r_parity  <= w_parity_n;
`endif
      end
   end

   assign tx_ready = r_ready;
   assign tx       = r_tx;
   assign busy     = r_busy;
   assign done     = r_done;

endmodule

// File: tb/tb_serial_transmitter.sv
// Testbench for serial_transmitter. Two instances share clk and reset:
// dut0 runs with CLKS_PER_BIT=1 and dut1 with CLKS_PER_BIT=4.
// A frame-level model predicts every output on every cycle. Its inputs are
// the accepted byte and the clock offset since acceptance. Directed literal
// checks pin the model itself.
module tb_serial_transmitter;

   localparam int DW   = 8;
   localparam int CPB0 = 1;
   localparam int CPB1 = 4;
`ifdef SERIAL_TX_PARITY_EN
   localparam int NB = DW + 3;
`else
   localparam int NB = DW + 2;
`endif

   logic          clk;
   logic          reset;
   logic [1:0]    vin;
   logic [DW-1:0] din [2];
   logic [1:0]    o_rdy, o_tx, o_busy, o_done;

   int checks = 0;
   int errors = 0;
   logic chk_en = 1'b0;

   // Frame-level model state.
   logic [1:0]    m_act;
   int            m_t [2];
   logic [DW-1:0] m_byte [2];

   serial_transmitter #(.DATA_W(DW), .CLKS_PER_BIT(CPB0)) dut0 (
      .clk(clk), .reset(reset), .tx_valid(vin[0]), .tx_data(din[0]),
      .tx_ready(o_rdy[0]), .tx(o_tx[0]), .busy(o_busy[0]), .done(o_done[0]));

   serial_transmitter #(.DATA_W(DW), .CLKS_PER_BIT(CPB1)) dut1 (
      .clk(clk), .reset(reset), .tx_valid(vin[1]), .tx_data(din[1]),
      .tx_ready(o_rdy[1]), .tx(o_tx[1]), .busy(o_busy[1]), .done(o_done[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int cpb_of(input int i);
      return (i == 0) ? CPB0 : CPB1;
   endfunction

   // Line value of frame bit idx: start, data LSB first, [parity], stop.
   function automatic logic frame_bit(input logic [DW-1:0] b, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= DW) return b[idx-1];
`ifdef SERIAL_TX_PARITY_EN
      if (idx == DW + 1) return ^b;
`endif
      return 1'b1;
   endfunction

   // Model: a frame occupies NB*cpb clocks after acceptance, while idle only.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            m_act[i] <= 1'b0;
         end else if (m_act[i]) begin
            if (m_t[i] == NB * cpb_of(i) - 1) m_act[i] <= 1'b0;
            else m_t[i] <= m_t[i] + 1;
         end else if (vin[i]) begin
            m_act[i]  <= 1'b1;
            m_t[i]    <= 0;
            m_byte[i] <= din[i];
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: wait for the falling edge, then compare every output with the model.
   task automatic cycle();
      logic e_tx, e_busy, e_rdy, e_done;
      @(negedge clk);
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            if (m_act[i]) begin
               e_tx   = frame_bit(m_byte[i], m_t[i] / cpb_of(i));
               e_busy = 1'b1;
               e_rdy  = 1'b0;
               e_done = (m_t[i] == NB * cpb_of(i) - 1);
            end else begin
               e_tx = 1'b1; e_busy = 1'b0; e_rdy = 1'b1; e_done = 1'b0;
            end
            chk($sformatf("tx%0d", i),    {31'd0, o_tx[i]},   {31'd0, e_tx});
            chk($sformatf("busy%0d", i),  {31'd0, o_busy[i]}, {31'd0, e_busy});
            chk($sformatf("ready%0d", i), {31'd0, o_rdy[i]},  {31'd0, e_rdy});
            chk($sformatf("done%0d", i),  {31'd0, o_done[i]}, {31'd0, e_done});
         end
      end
   endtask

   initial begin
      logic [NB-1:0] got;
      logic [NB-1:0] exp_seq;
      logic [DW-1:0] gd;
      int nd, dpos, nbusy;

      reset = 1'b1;
      vin = 2'b00;
      din[0] = 8'h00;
      din[1] = 8'h00;
      cycle();
      cycle();
      chk_en = 1'b1;
      cycle();
      chk("rst_tx", {30'd0, o_tx}, 32'd3);
      chk("rst_ready", {30'd0, o_rdy}, 32'd3);
      reset = 1'b0;

      // Idle for 20 clocks: no done pulse.
      nd = 0;
      for (int k = 0; k < 20; k++) begin
         cycle();
         nd += int'(o_done[0]) + int'(o_done[1]);
      end
      chk("idle_done", nd, 0);
      chk("idle_line", {28'd0, o_tx, o_busy}, {28'd0, 2'b11, 2'b00});

      // 0xA5 at one clock per bit: exact line sequence and done position.
      vin[0] = 1'b1; din[0] = 8'hA5;
      nd = 0; dpos = -1;
      for (int k = 0; k < NB; k++) begin
         cycle();
         vin[0] = 1'b0;
         got[k] = o_tx[0];
         if (o_done[0]) begin nd++; dpos = k; end
      end
`ifdef SERIAL_TX_PARITY_EN
      exp_seq = 11'b10101001010;
      chk("a5_done_pos", dpos, 10);
`else
      exp_seq = 10'b1101001010;
      chk("a5_done_pos", dpos, 9);
`endif
      chk("a5_seq", {{(32-NB){1'b0}}, got}, {{(32-NB){1'b0}}, exp_seq});
      chk("a5_done_cnt", nd, 1);
      cycle();
      chk("a5_ready_after", {31'd0, o_rdy[0]}, 32'd1);

      // 0x3C at four clocks per bit: busy length and mid-bit data samples.
      vin[1] = 1'b1; din[1] = 8'h3C;
      nbusy = 0; gd = 8'h00;
      for (int k = 0; k < 60; k++) begin
         cycle();
         vin[1] = 1'b0;
         if (o_busy[1]) nbusy++;
         if (k >= 5 && k <= 33 && ((k - 5) % 4) == 0) gd[(k-5)/4] = o_tx[1];
      end
      chk("3c_busy_len", nbusy, NB * 4);
      chk("3c_data", {24'd0, gd}, 32'h3C);

      // Back-to-back with tx_valid held: 0x01 then 0xFF, one idle clock between.
      vin[0] = 1'b1; din[0] = 8'h01;
      for (int k = 0; k <= 2 * NB; k++) begin
         cycle();
         if (k == 5) chk("b2b_mid_change", {31'd0, o_tx[0]}, 32'd0);
         if (k == NB) chk("b2b_gap", {30'd0, o_tx[0], o_rdy[0]}, 32'd3);
         if (k == NB + 1) chk("b2b_start2", {31'd0, o_tx[0]}, 32'd0);
         if (k == NB + 5) chk("b2b_ff_bit", {31'd0, o_tx[0]}, 32'd1);
         if (k == 3) din[0] = 8'hFF;
         if (k == NB + 1) vin[0] = 1'b0;
         if (k == NB + 3) din[0] = 8'h00;
      end
      repeat (3) cycle();

      // Reset on clock 5 of a 0x00 frame aborts it without done.
      vin[0] = 1'b1; din[0] = 8'h00;
      for (int k = 0; k < 5; k++) begin
         cycle();
         vin[0] = 1'b0;
      end
      reset = 1'b1;
      cycle();
      chk("abort_line", {30'd0, o_tx[0], o_busy[0]}, 32'd2);
      reset = 1'b0;
      nd = 0;
      for (int k = 0; k < NB + 2; k++) begin
         cycle();
         nd += int'(o_done[0]);
      end
      chk("abort_no_done", nd, 0);

      // The frame after reset transmits correctly.
      vin[0] = 1'b1; din[0] = 8'h5A;
      gd = 8'h00;
      for (int k = 0; k < NB + 1; k++) begin
         cycle();
         vin[0] = 1'b0;
         if (k >= 1 && k <= DW) gd[k-1] = o_tx[0];
      end
      chk("post_reset_data", {24'd0, gd}, 32'h5A);

`ifdef SERIAL_TX_PARITY_EN
      // Parity bit for 0x07 is 1 and for 0x03 is 0; frame is 11 clocks.
      vin[0] = 1'b1; din[0] = 8'h07;
      nbusy = 0;
      for (int k = 0; k < NB + 1; k++) begin
         cycle();
         vin[0] = 1'b0;
         if (o_busy[0]) nbusy++;
         if (k == DW + 1) chk("par_07", {31'd0, o_tx[0]}, 32'd1);
      end
      chk("par_frame_len", nbusy, 11);
      vin[0] = 1'b1; din[0] = 8'h03;
      for (int k = 0; k < NB + 1; k++) begin
         cycle();
         vin[0] = 1'b0;
         if (k == DW + 1) chk("par_03", {31'd0, o_tx[0]}, 32'd0);
      end
`endif

      repeat (4) cycle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_transmitter.md
Name: serial_transmitter

Overview:
Serial line transmitter and the transmit end of the team's start/data/stop serial link. The line idles high. Each frame is one start bit (0), DATA_W data bits sent LSB first, then one stop bit (1), so frames decode directly in the existing serial receiver. A parallel valid/ready handshake accepts one byte per frame from upstream logic; every bit is held for CLKS_PER_BIT clocks.

Parameters:
DATA_W, 8, number of data bits per frame (1..16)
CLKS_PER_BIT, 1, clocks each serial bit is held on tx (1..65535)

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
tx_valid  input  1  upstream has a byte on tx_data
tx_data  input  DATA_W  byte to send; sampled only on handshake
tx_ready  output  1  transmitter idle and able to accept a byte
tx  output  1  serial line, registered, idle high
busy  output  1  high while a frame is on the line
done  output  1  one-cycle pulse on the last clock of the stop bit

Behaviour:
- Reset, which is synchronous and active-high (clk is the clock): state IDLE, tx=1, tx_ready=1, busy=0, done=0, bit counter 0, clock divider counter 0, shift register 0.
- States: IDLE, START, DATA, STOP. PARITY is added only when the optional feature is compiled in.
- Handshake: a byte is accepted on a rising edge where tx_valid=1 and tx_ready=1. tx_ready is a registered output and equals (state==IDLE).
  - tx_data is latched into the shift register at acceptance.
  - tx_data may change freely afterwards.
  - tx_valid with tx_ready=0 has no effect; the byte is not queued.
- Latency: tx drops to 0 on the clock edge after acceptance. busy goes high at the same edge.
- Divider counter runs 0..CLKS_PER_BIT-1 in every non-IDLE state. A bit period ends when the counter reaches CLKS_PER_BIT-1; the counter then returns to 0.
- IDLE -> START on handshake. tx=0.
- START -> DATA at end of bit period. tx=shift[0], bit counter 0.
- DATA: at the end of each bit period, shift right and increment the bit counter. tx takes the next LSB.
  - After bit DATA_W-1 completes: -> STOP with tx=1.
  - With the optional feature: -> PARITY instead.
- STOP -> IDLE at end of bit period.
  - done=1 for exactly that last stop clock.
  - tx stays 1.
  - tx_ready and busy return to 1/0 on the next edge.
- Frame length: (DATA_W+2)*CLKS_PER_BIT clocks of busy=1, or (DATA_W+3)*CLKS_PER_BIT with parity.
- Back-to-back: a new handshake is possible in the first IDLE cycle. Its start bit follows the stop bit with exactly one extra idle-high clock; no longer gap is inserted.
- Bit counter is $clog2(DATA_W+1) bits wide. The divider counter is 16 bits wide. Neither counter wraps mid-frame.
- Reset mid-frame aborts immediately: tx=1 on the next edge, the partial frame is discarded, and done is not pulsed.
- Illegal/unused state encodings return to IDLE with tx=1.

Optional Feature:
Macro SERIAL_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It is held for CLKS_PER_BIT clocks and drives even parity, i.e. XOR of all DATA_W bits of the latched byte, computed at acceptance.
- Undefined: no PARITY state; DATA goes directly to STOP. The frame is bit-compatible with the existing receiver.

Test Plan:
- Reset then idle 20 clocks -> tx=1, tx_ready=1, busy=0, done never asserted.
- CLKS_PER_BIT=1, send 0xA5 -> tx over 10 clocks = 0,1,0,1,0,0,1,0,1,1; done high on clock 10 only; tx_ready high on clock 11.
- CLKS_PER_BIT=4, send 0x3C -> each bit held 4 clocks; 40 busy clocks; data bits on the line 0,0,1,1,1,1,0,0.
- tx_valid held high with 0x01 then 0xFF -> two frames separated by exactly one idle-high clock. A mid-frame change of tx_data does not alter the line.
- Assert reset on clock 5 of a 0x00 frame -> tx=1 on the next edge, busy=0, no done pulse. The next frame after reset transmits correctly.
- SERIAL_TX_PARITY_EN defined, send 0x07 -> parity bit 1 before stop; send 0x03 -> parity bit 0; frame 11 clocks at CLKS_PER_BIT=1.
